// File: rtl/mips_pkg.sv
// Shared types for the unified-memory port arbiter.
// Holds the FSM state and owner encodings, plus the latency limit.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } arb_state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } arb_owner_t;

  localparam int unsigned MEM_LATENCY_MAX = 15;
  localparam int unsigned CNT_W           = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF and MEM accesses onto one fixed-latency memory port.
// Also generates the matching pipeline stall and flush signals.
module mem_port_arbiter
  import mips_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        stallF,
  output logic        stallD,
  output logic        stallE,
  output logic        stallM,
  output logic        flushW
);

  localparam logic [CNT_W-1:0] LatCnt = CNT_W'(MEM_LATENCY);

  arb_state_t       state_q, state_d;
  arb_owner_t       owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             we_q, we_d;
  logic [31:0]      if_rdata_q, if_rdata_d;
  logic [31:0]      dm_rdata_q, dm_rdata_d;
  logic             if_done_q, if_done_d;
  logic             dm_done_q, dm_done_d;

  logic dwait;
  logic want_d;
  logic want_i;
  logic capture;

  assign dwait  = dm_req & ~dm_done_q;
  assign stallE = dwait;
  assign stallM = dwait;
  assign flushW = dwait;
  assign stallF = (if_req & ~if_done_q) | dwait;
  assign stallD = stallF;

  // In DONE the owner's own request is masked so a finished access is never reissued.
  assign want_d  = dm_req & ~dm_done_q & ~((state_q == DONE) && (owner_q == OWN_D));
  assign want_i  = if_req & ~if_done_q & ~((state_q == DONE) && (owner_q == OWN_I));
  assign capture = (state_q == WAIT) && (cnt_q == 4'd1);

  assign mem_en    = (state_q == ISSUE);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_ready  = if_done_q;
  assign dm_ready  = dm_done_q;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    if_done_d  = if_done_q;
    dm_done_d  = dm_done_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (want_d) begin
          owner_d = OWN_D;
          addr_d  = dm_addr;
          we_d    = dm_we;
          wdata_d = dm_wdata;
          state_d = ISSUE;
        end else if (want_i) begin
          owner_d = OWN_I;
          addr_d  = if_addr;
          we_d    = 1'b0;
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        cnt_d   = LatCnt;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (capture) begin
          state_d = DONE;
          if (owner_q == OWN_I) begin
            if_rdata_d = mem_rdata;
          end else if (!we_q) begin
            dm_rdata_d = mem_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Results stay visible until the stage consuming them is no longer held.
    if (!stallF) if_done_d = 1'b0;
    if (!stallM) dm_done_d = 1'b0;
    if (capture) begin
      if (owner_q == OWN_D) dm_done_d = 1'b1;
      else                  if_done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= OWN_I;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      if_done_q  <= 1'b0;
      dm_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      if_done_q  <= if_done_d;
      dm_done_q  <= dm_done_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed cycle vectors, an L=1 sequence and
// randomized traffic checked against a transaction-timeline model.
module tb_mem_port_arbiter;

  localparam int L = 2;
  localparam int NRAND = 3000;
  localparam logic [31:0] J = 32'h1357_9BDF;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_ready, dm_ready, mem_en, mem_we;
  logic        stallF, stallD, stallE, stallM, flushW;

  logic        l1_if_req, l1_dm_req, l1_dm_we;
  logic [31:0] l1_if_addr, l1_dm_addr, l1_dm_wdata, l1_mem_rdata;
  logic [31:0] l1_if_rdata, l1_dm_rdata, l1_mem_addr, l1_mem_wdata;
  logic        l1_if_ready, l1_dm_ready, l1_mem_en, l1_mem_we;
  logic        l1_stallF, l1_stallD, l1_stallE, l1_stallM, l1_flushW;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LATENCY(L)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM), .flushW(flushW)
  );

  mem_port_arbiter #(.MEM_LATENCY(1)) dut_l1 (
    .clk(clk), .reset(reset),
    .if_req(l1_if_req), .if_addr(l1_if_addr), .if_rdata(l1_if_rdata),
    .if_ready(l1_if_ready),
    .dm_req(l1_dm_req), .dm_we(l1_dm_we), .dm_addr(l1_dm_addr), .dm_wdata(l1_dm_wdata),
    .dm_rdata(l1_dm_rdata), .dm_ready(l1_dm_ready),
    .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr),
    .mem_wdata(l1_mem_wdata), .mem_rdata(l1_mem_rdata),
    .stallF(l1_stallF), .stallD(l1_stallD), .stallE(l1_stallE), .stallM(l1_stallM),
    .flushW(l1_flushW)
  );

  typedef struct {
    bit rst, ifr, dr, dwe;
    logic [31:0] ia, da, dwd, mrd;
    bit en, we;
    logic [31:0] maddr;
    bit ifrdy;
    logic [31:0] ifrd;
    bit dmrdy;
    logic [31:0] dmrd;
    bit sf, sm;
  } vec_t;

  vec_t vt[$];
  logic [31:0] cur_ia, cur_da, cur_dwd;
  int checks = 0;
  int failures = 0;
  string ctx = "";

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %s: got 0x%08h, expected 0x%08h", name, ctx, act, exp);
    end
  endtask

  task automatic addrs(input logic [31:0] ia, input logic [31:0] da, input logic [31:0] dwd);
    cur_ia = ia; cur_da = da; cur_dwd = dwd;
  endtask

  task automatic row(input bit rst, input bit ifr, input bit dr, input bit dwe,
                     input logic [31:0] mrd, input bit en, input bit we,
                     input logic [31:0] maddr, input bit ifrdy, input logic [31:0] ifrd,
                     input bit dmrdy, input logic [31:0] dmrd, input bit sf, input bit sm);
    vec_t v;
    v.rst = rst; v.ifr = ifr; v.dr = dr; v.dwe = dwe;
    v.ia = cur_ia; v.da = cur_da; v.dwd = cur_dwd; v.mrd = mrd;
    v.en = en; v.we = we; v.maddr = maddr; v.ifrdy = ifrdy; v.ifrd = ifrd;
    v.dmrdy = dmrdy; v.dmrd = dmrd; v.sf = sf; v.sm = sm;
    vt.push_back(v);
  endtask

  // Compares every main-DUT output whose value is fully determined each cycle.
  task automatic chk_outs(input bit en, input bit we, input bit ifrdy, input logic [31:0] ifrd,
                          input bit dmrdy, input logic [31:0] dmrd, input bit sf, input bit sm);
    chk("mem_en", mem_en, en);
    chk("mem_we", mem_we, we);
    chk("if_ready", if_ready, ifrdy);
    chk("if_rdata", if_rdata, ifrd);
    chk("dm_ready", dm_ready, dmrdy);
    chk("dm_rdata", dm_rdata, dmrd);
    chk("stallF", stallF, sf);
    chk("stallD", stallD, sf);
    chk("stallE", stallE, sm);
    chk("stallM", stallM, sm);
    chk("flushW", flushW, sm);
  endtask

  task automatic l1_step(input bit req, input logic [31:0] mrd, input bit e_en,
                         input bit e_rdy, input logic [31:0] e_rd, input bit e_sm, input string nm);
    @(posedge clk); #1;
    l1_dm_req = req; l1_mem_rdata = mrd;
    @(negedge clk);
    ctx = nm;
    chk("l1_mem_en", l1_mem_en, e_en);
    chk("l1_mem_we", l1_mem_we, 1'b0);
    if (e_en) chk("l1_mem_addr", l1_mem_addr, 32'h1001_0010);
    chk("l1_dm_ready", l1_dm_ready, e_rdy);
    chk("l1_dm_rdata", l1_dm_rdata, e_rd);
    chk("l1_stallM", l1_stallM, e_sm);
    chk("l1_stallE", l1_stallE, e_sm);
    chk("l1_flushW", l1_flushW, e_sm);
    chk("l1_stallF", l1_stallF, e_sm);
    chk("l1_stallD", l1_stallD, e_sm);
    chk("l1_if_ready", l1_if_ready, 1'b0);
    chk("l1_if_rdata", l1_if_rdata, 32'h0);
    chk("l1_mem_wdata", l1_mem_wdata, 32'h0);
  endtask

  function automatic logic [31:0] memval(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Reference model: one in-flight job described by its arbitration cycle.
  bit          m_busy, m_jd, m_jwe, m_ifd, m_dmd;
  logic [31:0] m_jaddr, m_jwdata, m_ifr, m_dmr;
  int          m_jstart;
  bit          resp_v[16];
  logic [31:0] resp_a[16];
  bit          prev_if_ready, prev_dm_ready, prev_stallF;
  logic [31:0] pc;

  task automatic new_dm();
    dm_req = 1'b1;
    dm_we = 1'($urandom_range(1));
    dm_addr = $urandom & 32'hFFFF_FFFC;
    dm_wdata = $urandom;
  endtask

  initial begin
    reset = 1'b1;
    if_req = 0; dm_req = 0; dm_we = 0; if_addr = 0; dm_addr = 0; dm_wdata = 0; mem_rdata = 0;
    l1_if_req = 0; l1_dm_req = 0; l1_dm_we = 0; l1_if_addr = 0; l1_dm_addr = 0;
    l1_dm_wdata = 0; l1_mem_rdata = 0;

    // Single fetch.
    addrs(32'h0040_0000, 32'h0, 32'h0);
    row(0,1,0,0,J,           0,0,0,            0,0,            0,0,     1,0);
    row(0,1,0,0,J,           1,0,32'h0040_0000,0,0,            0,0,     1,0);
    row(0,1,0,0,J,           0,0,0,            0,0,            0,0,     1,0);
    row(0,1,0,0,32'h8C08_0004,0,0,0,           0,0,            0,0,     1,0);
    row(0,1,0,0,J,           0,0,0,            1,32'h8C08_0004,0,0,     0,0);
    row(0,0,0,0,J,           0,0,0,            0,32'h8C08_0004,0,0,     0,0);
    // Simultaneous load and fetch: data first.
    addrs(32'h0040_0004, 32'h1001_0000, 32'h0);
    row(0,1,1,0,J,           0,0,0,            0,32'h8C08_0004,0,0,     1,1);
    row(0,1,1,0,J,           1,0,32'h1001_0000,0,32'h8C08_0004,0,0,     1,1);
    row(0,1,1,0,J,           0,0,0,            0,32'h8C08_0004,0,0,     1,1);
    row(0,1,1,0,32'h0000_0042,0,0,0,           0,32'h8C08_0004,0,0,     1,1);
    row(0,1,1,0,J,           0,0,0,            0,32'h8C08_0004,1,32'h42,1,0);
    row(0,1,0,0,J,           1,0,32'h0040_0004,0,32'h8C08_0004,0,32'h42,1,0);
    row(0,1,0,0,J,           0,0,0,            0,32'h8C08_0004,0,32'h42,1,0);
    row(0,1,0,0,32'h2402_0001,0,0,0,           0,32'h8C08_0004,0,32'h42,1,0);
    row(0,1,0,0,J,           0,0,0,            1,32'h2402_0001,0,32'h42,0,0);
    row(0,0,0,0,J,           0,0,0,            0,32'h2402_0001,0,32'h42,0,0);
    // Store: dm_rdata must keep the earlier load value.
    addrs(32'h0040_0004, 32'h1001_0008, 32'hDEAD_BEEF);
    row(0,0,1,1,J,           0,0,0,            0,32'h2402_0001,0,32'h42,1,1);
    row(0,0,1,1,J,           1,1,32'h1001_0008,0,32'h2402_0001,0,32'h42,1,1);
    row(0,0,1,1,J,           0,0,0,            0,32'h2402_0001,0,32'h42,1,1);
    row(0,0,1,1,32'h5555_5555,0,0,0,           0,32'h2402_0001,0,32'h42,1,1);
    row(0,0,1,1,J,           0,0,0,            0,32'h2402_0001,1,32'h42,0,0);
    row(0,0,0,0,J,           0,0,0,            0,32'h2402_0001,0,32'h42,0,0);
    // Fetch done, then a data stall holds if_ready and blocks a new fetch.
    addrs(32'h0040_0008, 32'h1001_000C, 32'hDEAD_BEEF);
    row(0,1,0,0,J,           0,0,0,            0,32'h2402_0001,0,32'h42,1,0);
    row(0,1,0,0,J,           1,0,32'h0040_0008,0,32'h2402_0001,0,32'h42,1,0);
    row(0,1,0,0,J,           0,0,0,            0,32'h2402_0001,0,32'h42,1,0);
    row(0,1,0,0,32'h0109_5020,0,0,0,           0,32'h2402_0001,0,32'h42,1,0);
    row(0,1,1,0,J,           0,0,0,            1,32'h0109_5020,0,32'h42,1,1);
    row(0,1,1,0,J,           1,0,32'h1001_000C,1,32'h0109_5020,0,32'h42,1,1);
    row(0,1,1,0,J,           0,0,0,            1,32'h0109_5020,0,32'h42,1,1);
    row(0,1,1,0,32'h0000_00AA,0,0,0,           1,32'h0109_5020,0,32'h42,1,1);
    row(0,1,1,0,J,           0,0,0,            1,32'h0109_5020,1,32'hAA,0,0);
    addrs(32'h0040_000C, 32'h1001_000C, 32'hDEAD_BEEF);
    row(0,1,0,0,J,           0,0,0,            0,32'h0109_5020,0,32'hAA,1,0);
    row(0,1,0,0,J,           1,0,32'h0040_000C,0,32'h0109_5020,0,32'hAA,1,0);
    row(0,1,0,0,J,           0,0,0,            0,32'h0109_5020,0,32'hAA,1,0);
    row(0,1,0,0,32'h1234_5678,0,0,0,           0,32'h0109_5020,0,32'hAA,1,0);
    row(0,1,0,0,J,           0,0,0,            1,32'h1234_5678,0,32'hAA,0,0);
    row(0,0,0,0,J,           0,0,0,            0,32'h1234_5678,0,32'hAA,0,0);
    // Reset during WAIT: late response ignored, fetch restarts cleanly.
    addrs(32'h0040_0010, 32'h0, 32'h0);
    row(0,1,0,0,J,           0,0,0,            0,32'h1234_5678,0,32'hAA,1,0);
    row(0,1,0,0,J,           1,0,32'h0040_0010,0,32'h1234_5678,0,32'hAA,1,0);
    row(0,1,0,0,J,           0,0,0,            0,32'h1234_5678,0,32'hAA,1,0);
    row(1,1,0,0,32'h0BAD_F00D,0,0,0,           0,0,            0,0,     1,0);
    row(0,1,0,0,32'h0BAD_F00D,0,0,0,           0,0,            0,0,     1,0);
    row(0,1,0,0,J,           1,0,32'h0040_0010,0,0,            0,0,     1,0);
    row(0,1,0,0,J,           0,0,0,            0,0,            0,0,     1,0);
    row(0,1,0,0,32'h0000_CAFE,0,0,0,           0,0,            0,0,     1,0);
    row(0,1,0,0,J,           0,0,0,            1,32'h0000_CAFE,0,0,     0,0);
    row(0,0,0,0,J,           0,0,0,            0,32'h0000_CAFE,0,0,     0,0);

    repeat (2) @(posedge clk);
    foreach (vt[k]) begin
      @(posedge clk); #1;
      reset = vt[k].rst; if_req = vt[k].ifr; if_addr = vt[k].ia;
      dm_req = vt[k].dr; dm_we = vt[k].dwe; dm_addr = vt[k].da; dm_wdata = vt[k].dwd;
      mem_rdata = vt[k].mrd;
      @(negedge clk);
      ctx = $sformatf("vec%0d", k);
      chk_outs(vt[k].en, vt[k].we, vt[k].ifrdy, vt[k].ifrd, vt[k].dmrdy, vt[k].dmrd,
               vt[k].sf, vt[k].sm);
      if (vt[k].en) chk("mem_addr", mem_addr, vt[k].maddr);
      if (vt[k].we) chk("mem_wdata", mem_wdata, vt[k].dwd);
      if (vt[k].rst) begin
        chk("mem_addr_rst", mem_addr, 32'h0);
        chk("mem_wdata_rst", mem_wdata, 32'h0);
      end
    end

    // MEM_LATENCY=1 load.
    l1_dm_addr = 32'h1001_0010;
    l1_step(1, J,            0, 0, 32'h0,      1, "l1 c0");
    l1_step(1, J,            1, 0, 32'h0,      1, "l1 c1");
    l1_step(1, 32'h0000_BEEF, 0, 0, 32'h0,      1, "l1 c2");
    l1_step(1, J,            0, 1, 32'h0000_BEEF, 0, "l1 c3");
    l1_step(0, J,            0, 0, 32'h0000_BEEF, 0, "l1 c4");

    // Randomized traffic against the timeline model.
    @(posedge clk); #1;
    reset = 1'b1; if_req = 0; dm_req = 0; dm_we = 0; mem_rdata = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    m_busy = 0; m_jd = 0; m_jwe = 0; m_ifd = 0; m_dmd = 0; m_jstart = -100;
    m_jaddr = 0; m_jwdata = 0; m_ifr = 0; m_dmr = 0;
    prev_if_ready = 0; prev_dm_ready = 0; prev_stallF = 0; pc = 32'h0040_0000;
    for (int i = 0; i < 16; i++) resp_v[i] = 0;

    for (int t = 0; t < NRAND; t++) begin
      bit e_en, e_we, dw, sf, done_cyc, n_ifd, n_dmd, wd, wi;
      if (t > 0) begin
        @(posedge clk); #1;
      end
      if (dm_req) begin
        if (prev_dm_ready) begin
          if ($urandom_range(2) == 0) new_dm();
          else dm_req = 1'b0;
        end else if ($urandom_range(59) == 0) begin
          dm_req = 1'b0;
        end
      end else if ($urandom_range(3) == 0) begin
        new_dm();
      end
      if (if_req && prev_if_ready && !prev_stallF) begin
        pc = pc + 32'd4;
        if_req = ($urandom_range(3) != 0);
      end else if (!if_req) begin
        if_req = 1'($urandom_range(1));
      end else if ($urandom_range(49) == 0) begin
        pc = $urandom & 32'hFFFF_FFFC;
      end
      if_addr = pc;
      if (resp_v[t % 16]) begin
        mem_rdata = memval(resp_a[t % 16]);
        resp_v[t % 16] = 0;
      end else begin
        mem_rdata = $urandom;
      end

      @(negedge clk);
      ctx = $sformatf("rand t=%0d", t);
      e_en = m_busy && (t == m_jstart + 1);
      e_we = e_en && m_jd && m_jwe;
      dw = dm_req && !m_dmd;
      sf = (if_req && !m_ifd) || dw;
      chk_outs(e_en, e_we, m_ifd, m_ifr, m_dmd, m_dmr, sf, dw);
      if (e_en) chk("mem_addr", mem_addr, m_jaddr);
      if (e_we) chk("mem_wdata", mem_wdata, m_jwdata);
      if (mem_en) begin
        resp_v[(t + L) % 16] = 1;
        resp_a[(t + L) % 16] = mem_addr;
      end
      prev_if_ready = if_ready; prev_dm_ready = dm_ready; prev_stallF = stallF;

      done_cyc = m_busy && (t == m_jstart + 2 + L);
      wd = dm_req && !m_dmd && !(done_cyc && m_jd);
      wi = if_req && !m_ifd && !(done_cyc && !m_jd);
      n_ifd = m_ifd && sf;
      n_dmd = m_dmd && dw;
      if (m_busy && (t == m_jstart + 1 + L)) begin
        if (m_jd) begin
          n_dmd = 1;
          if (!m_jwe) m_dmr = memval(m_jaddr);
        end else begin
          n_ifd = 1;
          m_ifr = memval(m_jaddr);
        end
      end
      if (!m_busy || done_cyc) begin
        if (wd) begin
          m_busy = 1; m_jd = 1; m_jwe = dm_we; m_jaddr = dm_addr; m_jwdata = dm_wdata;
          m_jstart = t;
        end else if (wi) begin
          m_busy = 1; m_jd = 0; m_jwe = 0; m_jaddr = if_addr; m_jstart = t;
        end else begin
          m_busy = 0;
        end
      end
      m_ifd = n_ifd;
      m_dmd = n_dmd;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
